// File: rtl/i2c_cfg_sequencer_if.sv
// Request/response bundle between the config sequencer and the I2C master wrapper.
// The sequencer is the master side: it drives the request and samples completion status.
interface i2c_cfg_sequencer_if;
    logic       iic_en;
    logic       wrrd;
    logic [6:0] slave_addr;
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
    logic       rd_clear;
    logic       i2c_busy;
    logic       iic_ack;
    logic       rd_vld;
    logic [7:0] rd_data;

    modport master (
        output iic_en, wrrd, slave_addr, reg_addr, wr_data, rd_clear,
        input  i2c_busy, iic_ack, rd_vld, rd_data
    );

    modport slave (
        input  iic_en, wrrd, slave_addr, reg_addr, wr_data, rd_clear,
        output i2c_busy, iic_ack, rd_vld, rd_data
    );
endinterface

// File: rtl/i2c_cfg_sequencer.sv
// Bring-up sequencer: walks a synchronous config ROM and issues one I2C write,
// read-compare or ms delay per entry, with per-entry retry and done/error reporting.
module i2c_cfg_sequencer #(
    parameter int CLK_IN_FREQ  = 6_000_000,
    parameter int TBL_AW       = 8,
    parameter int MAX_RETRY    = 3,
    parameter int BUSY_TIMEOUT = 16,
    parameter int XFER_TIMEOUT = 65535
) (
    input  logic                  i_mc,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic [TBL_AW-1:0]     o_tbl_addr,
    input  logic [31:0]           i_tbl_data,
    i2c_cfg_sequencer_if.master   iic,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [TBL_AW-1:0]     o_err_idx
);

    localparam int TICK_MAX = CLK_IN_FREQ / 1000 - 1;

    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_DLY = 2'b01;
    localparam logic [1:0] OP_END = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE,
        S_CHECK, S_FAIL, S_GAP, S_DELAY, S_DONE
    } state_t;

    state_t            state_q;
    logic [TBL_AW-1:0] idx_q;
    logic [TBL_AW-1:0] idx_nxt_d;
    logic              idx_last_d;
    logic [31:0]       entry_q;
    logic [7:0]        retry_q;
    logic [31:0]       tmr_q;
    logic [15:0]       ms_q;
    logic              fetch_ph_q;
    logic              pass_q;
    logic              en_q;
    logic              wrrd_q;
    logic [6:0]        sa_q;
    logic [7:0]        ra_q;
    logic [7:0]        wd_q;
    logic              rd_clear_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [TBL_AW-1:0] err_idx_q;

    always_comb begin
        idx_nxt_d  = idx_q + 1'b1;
        idx_last_d = &idx_q;
    end

    always_ff @(posedge i_mc) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            entry_q    <= '0;
            retry_q    <= '0;
            tmr_q      <= '0;
            ms_q       <= '0;
            fetch_ph_q <= 1'b0;
            pass_q     <= 1'b0;
            en_q       <= 1'b0;
            wrrd_q     <= 1'b0;
            sa_q       <= '0;
            ra_q       <= '0;
            wd_q       <= '0;
            rd_clear_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_idx_q  <= '0;
        end else begin
            rd_clear_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        err_idx_q  <= '0;
                        idx_q      <= '0;
                        retry_q    <= '0;
                        busy_q     <= 1'b1;
                        fetch_ph_q <= 1'b0;
                        state_q    <= S_FETCH;
                    end
                end
                // Phase 0 presents the address (and holds off while a stale transfer
                // is still running); phase 1 captures the ROM word one clock later.
                S_FETCH: begin
                    if (!fetch_ph_q) begin
                        if (!iic.i2c_busy) fetch_ph_q <= 1'b1;
                    end else begin
                        entry_q    <= i_tbl_data;
                        fetch_ph_q <= 1'b0;
                        state_q    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (entry_q[31:30] == OP_END) begin
                        state_q <= S_DONE;
                    end else if (entry_q[31:30] == OP_DLY) begin
                        ms_q    <= entry_q[15:0];
                        tmr_q   <= '0;
                        state_q <= S_DELAY;
                    end else begin
                        wrrd_q     <= (entry_q[31:30] != OP_WR);
                        sa_q       <= entry_q[29:23];
                        ra_q       <= entry_q[22:15];
                        wd_q       <= entry_q[7:0];
                        rd_clear_q <= 1'b1;
                        en_q       <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tmr_q   <= '0;
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (iic.i2c_busy) begin
                        en_q    <= 1'b0;
                        tmr_q   <= '0;
                        state_q <= S_WAIT_DONE;
                    end else if (tmr_q == 32'(BUSY_TIMEOUT - 1)) begin
                        en_q    <= 1'b0;
                        state_q <= S_FAIL;
                    end else begin
                        tmr_q <= tmr_q + 32'd1;
                    end
                end
                // Status is captured on the busy fall so CHECK judges a stable snapshot.
                S_WAIT_DONE: begin
                    if (!iic.i2c_busy) begin
                        pass_q  <= iic.iic_ack &&
                                   (!wrrd_q || (iic.rd_vld && (iic.rd_data == entry_q[7:0])));
                        state_q <= S_CHECK;
                    end else if (tmr_q == 32'(XFER_TIMEOUT - 1)) begin
                        state_q <= S_FAIL;
                    end else begin
                        tmr_q <= tmr_q + 32'd1;
                    end
                end
                S_CHECK: begin
                    if (pass_q) begin
                        retry_q <= '0;
                        if (idx_last_d) begin
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_nxt_d;
                            state_q <= S_FETCH;
                        end
                    end else begin
                        state_q <= S_FAIL;
                    end
                end
                S_FAIL: begin
                    if (retry_q < 8'(MAX_RETRY)) begin
                        retry_q <= retry_q + 8'd1;
                        tmr_q   <= '0;
                        state_q <= S_GAP;
                    end else begin
                        err_q     <= 1'b1;
                        err_idx_q <= idx_q;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                // Two guaranteed low clocks so the master sees a fresh rising edge.
                S_GAP: begin
                    if (tmr_q == 32'd1) begin
                        en_q    <= 1'b1;
                        state_q <= S_ISSUE;
                    end else begin
                        tmr_q <= tmr_q + 32'd1;
                    end
                end
                S_DELAY: begin
                    if (ms_q == 16'd0) begin
                        if (idx_last_d) begin
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_nxt_d;
                            state_q <= S_FETCH;
                        end
                    end else if (tmr_q == 32'(TICK_MAX)) begin
                        tmr_q <= '0;
                        ms_q  <= ms_q - 16'd1;
                    end else begin
                        tmr_q <= tmr_q + 32'd1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_tbl_addr     = idx_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_err          = err_q;
    assign o_err_idx      = err_idx_q;
    assign iic.iic_en     = en_q;
    assign iic.wrrd       = wrrd_q;
    assign iic.slave_addr = sa_q;
    assign iic.reg_addr   = ra_q;
    assign iic.wr_data    = wd_q;
    assign iic.rd_clear   = rd_clear_q;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Directed bench for i2c_cfg_sequencer: a behavioural I2C master answers requests,
// a scenario table drives full sequences, and hand sequences cover timing corners.
module tb_i2c_cfg_sequencer;

    localparam int AW = 8;
    localparam logic [31:0] END_E = 32'hC000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] tbl_addr;
    logic [31:0]   tbl_data;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [AW-1:0] err_idx;

    i2c_cfg_sequencer_if bus();

    i2c_cfg_sequencer #(
        .CLK_IN_FREQ (6_000_000),
        .TBL_AW      (AW),
        .MAX_RETRY   (3),
        .BUSY_TIMEOUT(16),
        .XFER_TIMEOUT(300)
    ) dut (
        .i_mc      (clk),
        .i_rst     (rst),
        .i_start   (start),
        .o_tbl_addr(tbl_addr),
        .i_tbl_data(tbl_data),
        .iic       (bus),
        .o_busy    (busy_o),
        .o_done    (done_o),
        .o_err     (err_o),
        .o_err_idx (err_idx)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [0:255];
    always @(posedge clk) tbl_data <= rom[tbl_addr];

    // Master model configuration (written only by the stimulus process)
    logic       m_rst;
    int         m_nacks;
    logic       m_never_busy;
    logic       m_stuck;
    logic [7:0] m_rd_val;
    int         m_base;

    // Master model state and per-transaction log
    int         rises;
    int         clears;
    int         bcnt;
    int         lowcnt;
    logic       en_d;
    logic [6:0] log_sa   [64];
    logic [7:0] log_ra   [64];
    logic [7:0] log_wd   [64];
    logic       log_wrrd [64];
    int         log_gap  [64];

    always @(posedge clk) begin
        if (m_rst) begin
            rises        <= 0;
            clears       <= 0;
            bcnt         <= 0;
            lowcnt       <= 0;
            en_d         <= 1'b0;
            bus.i2c_busy <= 1'b0;
            bus.iic_ack  <= 1'b0;
            bus.rd_vld   <= 1'b0;
            bus.rd_data  <= 8'h00;
        end else begin
            en_d   <= bus.iic_en;
            lowcnt <= bus.iic_en ? 0 : lowcnt + 1;
            if (bus.rd_clear) begin
                clears     <= clears + 1;
                bus.rd_vld <= 1'b0;
            end
            if (bus.iic_en && !en_d) begin
                rises                     <= rises + 1;
                log_sa[6'(rises + 1)]     <= bus.slave_addr;
                log_ra[6'(rises + 1)]     <= bus.reg_addr;
                log_wd[6'(rises + 1)]     <= bus.wr_data;
                log_wrrd[6'(rises + 1)]   <= bus.wrrd;
                log_gap[6'(rises + 1)]    <= lowcnt;
                if (!m_never_busy) bcnt <= 1;
            end else if (bcnt == 7) begin
                bcnt <= 0;
                if (!m_stuck) begin
                    bus.i2c_busy <= 1'b0;
                    bus.iic_ack  <= ((rises - m_base) > m_nacks);
                    if (bus.wrrd) begin
                        bus.rd_vld  <= 1'b1;
                        bus.rd_data <= m_rd_val;
                    end
                end
            end else if (bcnt > 0) begin
                if (bcnt == 2) bus.i2c_busy <= 1'b1;
                bcnt <= bcnt + 1;
            end else if (!m_stuck && bus.i2c_busy) begin
                bus.i2c_busy <= 1'b0;
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] wr(input logic [6:0] sa, input logic [7:0] ra, input logic [7:0] d);
        return {2'b00, sa, ra, 7'd0, d};
    endfunction

    function automatic logic [31:0] rdc(input logic [6:0] sa, input logic [7:0] ra, input logic [7:0] d);
        return {2'b10, sa, ra, 7'd0, d};
    endfunction

    function automatic logic [31:0] dly(input logic [15:0] ms);
        return {2'b01, 14'd0, ms};
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int limit);
        int n = 0;
        while (busy_o && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    task automatic set_model(input int nacks, input logic nb, input logic stuck, input logic [7:0] rdv);
        m_nacks      = nacks;
        m_never_busy = nb;
        m_stuck      = stuck;
        m_rd_val     = rdv;
        m_base       = rises;
    endtask

    typedef struct {
        logic [31:0] e0, e1, e2, e3;
        int          nacks;
        logic        nb;
        logic        stuck;
        logic [7:0]  rdv;
        logic        x_done;
        logic        x_err;
        logic [7:0]  x_idx;
        int          x_rises;
        int          x_clears;
        logic [6:0]  x_sa;
        logic [7:0]  x_ra;
        logic [7:0]  x_wd;
        logic        x_wrrd;
    } vec_t;

    vec_t vecs [7];
    int   base_s [7];
    int   clr_s;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{wr(7'h48, 8'h01, 8'hA5), wr(7'h48, 8'h02, 8'h5A), END_E, END_E,
                    0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 2, 2, 7'h48, 8'h01, 8'hA5, 1'b0};
        vecs[1] = '{rdc(7'h48, 8'h10, 8'h3C), END_E, END_E, END_E,
                    0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h00, 1, 1, 7'h48, 8'h10, 8'h3C, 1'b1};
        vecs[2] = '{rdc(7'h48, 8'h10, 8'h3C), END_E, END_E, END_E,
                    0, 1'b0, 1'b0, 8'h3D, 1'b0, 1'b1, 8'h00, 4, 1, 7'h48, 8'h10, 8'h3C, 1'b1};
        vecs[3] = '{wr(7'h48, 8'h01, 8'hA5), END_E, END_E, END_E,
                    1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 2, 1, 7'h48, 8'h01, 8'hA5, 1'b0};
        vecs[4] = '{wr(7'h1A, 8'h20, 8'h11), END_E, END_E, END_E,
                    0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 4, 1, 7'h1A, 8'h20, 8'h11, 1'b0};
        vecs[5] = '{wr(7'h50, 8'h33, 8'h44), END_E, END_E, END_E,
                    0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 4, 1, 7'h50, 8'h33, 8'h44, 1'b0};
        vecs[6] = '{wr(7'h48, 8'h01, 8'hA5), wr(7'h48, 8'h02, 8'h5A), rdc(7'h48, 8'h30, 8'h77), END_E,
                    0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 8'h02, 6, 3, 7'h48, 8'h01, 8'hA5, 1'b0};

        for (int i = 0; i < 256; i++) rom[i] = END_E;
        rst   = 1'b1;
        m_rst = 1'b1;
        start = 1'b0;
        m_base = 0;
        set_model(0, 1'b0, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done_err", 32'({done_o, err_o}), 32'd0);
        check("rst_idx_addr", 32'({err_idx, tbl_addr}), 32'd0);
        check("rst_en_clr", 32'({bus.iic_en, bus.rd_clear}), 32'd0);
        rst   = 1'b0;
        m_rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            rom[0] = vecs[i].e0;
            rom[1] = vecs[i].e1;
            rom[2] = vecs[i].e2;
            rom[3] = vecs[i].e3;
            set_model(vecs[i].nacks, vecs[i].nb, vecs[i].stuck, vecs[i].rdv);
            base_s[i] = rises;
            clr_s     = clears;
            pulse_start();
            wait_idle($sformatf("v%0d", i), 6000);
            check($sformatf("v%0d_done", i), 32'(done_o), 32'(vecs[i].x_done));
            check($sformatf("v%0d_err", i), 32'(err_o), 32'(vecs[i].x_err));
            check($sformatf("v%0d_err_idx", i), 32'(err_idx), 32'(vecs[i].x_idx));
            check($sformatf("v%0d_rises", i), 32'(rises - base_s[i]), 32'(vecs[i].x_rises));
            check($sformatf("v%0d_clears", i), 32'(clears - clr_s), 32'(vecs[i].x_clears));
            check($sformatf("v%0d_fields", i),
                  32'({log_sa[6'(base_s[i] + 1)], log_ra[6'(base_s[i] + 1)],
                       log_wd[6'(base_s[i] + 1)], log_wrrd[6'(base_s[i] + 1)]}),
                  32'({vecs[i].x_sa, vecs[i].x_ra, vecs[i].x_wd, vecs[i].x_wrrd}));
        end

        check("v0_second_fields",
              32'({log_sa[6'(base_s[0] + 2)], log_ra[6'(base_s[0] + 2)],
                   log_wd[6'(base_s[0] + 2)], log_wrrd[6'(base_s[0] + 2)]}),
              32'({7'h48, 8'h02, 8'h5A, 1'b0}));
        check("nack_retry_gap_ge2", 32'(log_gap[6'(base_s[3] + 2)] >= 2), 32'd1);
        check("nobusy_retry_gap_ge2", 32'(log_gap[6'(base_s[4] + 2)] >= 2), 32'd1);

        // Restart after an error (last table row ended with err at entry 2)
        rom[0] = wr(7'h48, 8'h01, 8'hA5);
        rom[1] = END_E;
        set_model(0, 1'b0, 1'b0, 8'h00);
        pulse_start();
        check("restart_err_clr", 32'({err_o, err_idx}), 32'd0);
        check("restart_busy_addr", 32'({busy_o, tbl_addr}), 32'({1'b1, 8'h00}));
        wait_idle("restart", 6000);
        check("restart_done", 32'({done_o, err_o}), 32'({1'b1, 1'b0}));

        // Delay timing: 2 ms then 0 ms
        begin
            int n1;
            int n2;
            rom[0] = dly(16'd2);
            rom[1] = dly(16'd0);
            rom[2] = END_E;
            pulse_start();
            n1 = 0;
            while (tbl_addr != 8'd1 && n1 < 20000) begin
                @(negedge clk);
                n1++;
            end
            n2 = 0;
            while (tbl_addr != 8'd2 && n2 < 100) begin
                @(negedge clk);
                n2++;
            end
            check("dly2ms_in_window", 32'((n1 - 3 >= 11998) && (n1 - 3 <= 12002)), 32'd1);
            check("dly0ms_one_clk", 32'(n2 - 3), 32'd1);
            wait_idle("dly", 100);
            check("dly_done", 32'(done_o), 32'd1);
        end

        // Start pulse while running is ignored
        begin
            int n = 0;
            int b;
            rom[0] = wr(7'h48, 8'h01, 8'hA5);
            rom[1] = dly(16'd1);
            rom[2] = END_E;
            set_model(0, 1'b0, 1'b0, 8'h00);
            b = rises;
            pulse_start();
            while (tbl_addr != 8'd1 && n < 500) begin
                @(negedge clk);
                n++;
            end
            pulse_start();
            wait_idle("ign", 10000);
            check("ign_rises", 32'(rises - b), 32'd1);
            check("ign_done", 32'({done_o, err_o}), 32'({1'b1, 1'b0}));
        end

        // Reset while waiting for the transfer to complete
        begin
            int n = 0;
            rom[0] = wr(7'h48, 8'h01, 8'hA5);
            rom[1] = END_E;
            pulse_start();
            while (!(bus.i2c_busy && !bus.iic_en) && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("rstmid_reached", 32'(n < 200), 32'd1);
            rst = 1'b1;
            @(negedge clk);
            check("rstmid_en", 32'(bus.iic_en), 32'd0);
            check("rstmid_status", 32'({busy_o, done_o, err_o, err_idx}), 32'd0);
            check("rstmid_bus", 32'({bus.wrrd, bus.slave_addr, bus.reg_addr, bus.wr_data, bus.rd_clear}), 32'd0);
            check("rstmid_addr", 32'(tbl_addr), 32'd0);
            rst = 1'b0;
            set_model(0, 1'b0, 1'b0, 8'h00);
            pulse_start();
            wait_idle("rstmid", 6000);
            check("rstmid_rerun_done", 32'({done_o, err_o}), 32'({1'b1, 1'b0}));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
